// File: rtl/mole_spawner.sv
// Whack-a-mole scheduler: turns the random stream into mole timing/position and scores clicks.
// Optional MOLE_NO_REPEAT_EN keeps a mole from reappearing in the same hole twice in a row.
module mole_spawner #(
   parameter int HOLES       = 9,
   parameter int CLKS_PER_MS = 65000,
   parameter int UP_MIN_MS   = 400,
   parameter int GAP_MIN_MS  = 300,
   parameter int HIT_SHOW_MS = 200,
   parameter int MAX_MISSES  = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] random_number,
   input  logic       game_start,
   input  logic       click,
   input  logic [3:0] click_pos,
   output logic       mole_active,
   output logic       mole_hit,
   output logic [3:0] mole_pos,
   output logic [9:0] score,
   output logic [2:0] misses,
   output logic       hit_pulse,
   output logic       miss_pulse,
   output logic       game_over
);

   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

   if ((UP_MIN_MS + 500 > 2047) || (GAP_MIN_MS + 250 > 2047) || (HOLES < 2) || (HOLES > 16))
   begin : g_bad_params
      $error("mole_spawner: parameters out of range");
   end

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_UP, S_HIT, S_OVER} state_t;

   state_t         state;
   logic [PW-1:0]  presc;
   logic [10:0]    timer;
   logic [9:0]     r;
   logic [3:0]     hole;
   logic [3:0]     pos_next;
   logic [10:0]    gap_load;
   logic [10:0]    up_load;
   logic           run;
   logic           ms_tick;
   logic           expire;
   logic           click_match;

   always_comb begin
      r = random_number;
      if (random_number == 10'd0)
         r = 10'd1;
      else if (random_number > 10'd500)
         r = 10'd500;
   end

   assign hole     = 4'(r % 10'(HOLES));
   assign gap_load = 11'(GAP_MIN_MS) + {2'b00, r[9:1]};
   assign up_load  = 11'(UP_MIN_MS) + {1'b0, r};

`ifdef MOLE_NO_REPEAT_EN
   assign pos_next = (hole != mole_pos) ? hole :
                     (hole == 4'(HOLES - 1)) ? 4'd0 : hole + 4'd1;
`else
   assign pos_next = hole;
`endif

   assign run         = (state == S_WAIT) || (state == S_UP) || (state == S_HIT);
   assign ms_tick     = run && (presc == PW'(CLKS_PER_MS - 1));
   // The timer holds the ms still to run including the current one, so a load of N lasts N ticks.
   assign expire      = ms_tick && (timer <= 11'd1);
   assign click_match = click && (click_pos == mole_pos);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         presc       <= '0;
         timer       <= '0;
         mole_active <= 1'b0;
         mole_hit    <= 1'b0;
         mole_pos    <= '0;
         score       <= '0;
         misses      <= '0;
         hit_pulse   <= 1'b0;
         miss_pulse  <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         if (run)
            presc <= ms_tick ? '0 : presc + 1'b1;
         if (ms_tick && (timer != 11'd0))
            timer <= timer - 11'd1;

         case (state)
            S_IDLE, S_OVER: begin
               if (game_start) begin
                  score     <= '0;
                  misses    <= '0;
                  game_over <= 1'b0;
                  timer     <= gap_load;
                  presc     <= '0;
                  state     <= S_WAIT;
`ifdef MOLE_NO_REPEAT_EN
                  mole_pos  <= '0;
`endif
               end
            end
            S_WAIT: begin
               if (expire) begin
                  mole_pos    <= pos_next;
                  timer       <= up_load;
                  presc       <= '0;
                  mole_active <= 1'b1;
                  state       <= S_UP;
               end
            end
            S_UP: begin
               // A matching click wins over a timeout landing in the same cycle.
               if (click_match) begin
                  if (score != 10'd999)
                     score <= score + 10'd1;
                  hit_pulse   <= 1'b1;
                  timer       <= 11'(HIT_SHOW_MS);
                  presc       <= '0;
                  mole_active <= 1'b0;
                  mole_hit    <= 1'b1;
                  state       <= S_HIT;
               end else if (expire) begin
                  misses      <= misses + 3'd1;
                  miss_pulse  <= 1'b1;
                  presc       <= '0;
                  mole_active <= 1'b0;
                  if (misses + 3'd1 == 3'(MAX_MISSES)) begin
                     timer     <= '0;
                     game_over <= 1'b1;
                     state     <= S_OVER;
                  end else begin
                     timer <= gap_load;
                     state <= S_WAIT;
                  end
               end
            end
            S_HIT: begin
               if (expire) begin
                  mole_hit <= 1'b0;
                  timer    <= gap_load;
                  presc    <= '0;
                  state    <= S_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
